rom_stream_reader: RTL and testbench

- Avalon-MM read master that sits directly downstream of the platform on-chip ROM/RAM: 32-bit data, 1024 words, single port, one-cycle read latency.
- On a start command it fetches a contiguous run of words beginning at a base word address.
- It presents those words on a valid/ready stream with end-of-run marking, using a small internal FIFO to absorb sink backpressure.
- It feeds the processing/DMA logic that consumes boot tables and constant data held in the ROM.

---
 rtl/rom_stream_reader.sv | 115 +++++++++++
 tb/tb_rom_stream_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rom_stream_reader.sv
// Avalon-MM read master: fetches a contiguous run of ROM words and streams them
// out through a small credit-protected FIFO with end-of-run marking.
module rom_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W:0]   req_left_q, rsp_left_q;
  logic              inflight_q, busy_q, done_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic              fifo_last_q [FIFO_DEPTH];

  logic credit, issue, push, pop, head_last, not_empty;

  // A word in flight already owns a FIFO slot, so it counts against the credit.
  assign credit    = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign issue     = (state_q == READ) && (req_left_q != '0) && credit;
  assign push      = inflight_q;
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_cnt_q <= '0;
      req_left_q <= '0;
      rsp_left_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        IDLE: if (start) begin
          if (length != '0) begin
            addr_cnt_q <= base_addr;
            req_left_q <= length;
            rsp_left_q <= length;
            busy_q     <= 1'b1;
            state_q    <= READ;
          end else begin
            done_q <= 1'b1;
          end
        end
        READ: begin
          if (issue) begin
            addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
            req_left_q <= req_left_q - (ADDR_W+1)'(1);
          end
          if (push) begin
            rsp_left_q <= rsp_left_q - (ADDR_W+1)'(1);
            if (rsp_left_q == (ADDR_W+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: if (pop && head_last) begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_readdata;
        fifo_last_q[wr_ptr_q] <= (rsp_left_q == (ADDR_W+1)'(1));
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  // Reset is synchronous, so outputs are masked to show reset values immediately.
  assign mem_clken      = ~reset;
  assign mem_chipselect = issue & ~reset;
  assign mem_address    = reset ? '0 : addr_cnt_q;
  assign busy           = busy_q & ~reset;
  assign done           = done_q & ~reset;
  assign out_valid      = not_empty & ~reset;
  assign out_data       = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last       = out_valid & head_last;

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count_q == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a one-cycle-latency ROM model.
module tb_rom_stream_reader;
  localparam int AW = 10, DW = 32;

  logic clk = 1'b0;
  logic reset, start, out_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic busy, done, mem_chipselect, mem_clken, out_valid, out_last;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_readdata, out_data;

  int vecs = 0, errs = 0;
  logic [31:0] q_data[$];
  bit          q_last[$];
  logic [9:0]  q_addr[$];
  int n_done, done_cyc, busy_cnt, last_busy, first_valid, first_cs, cs_hold, n_last, stray_last;

  rom_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last));

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [9:0] a);
    return {12'hB00, a, ~a};
  endfunction

  // Garbage when not selected so mistimed captures show up as bad data.
  always @(posedge clk) mem_readdata <= mem_chipselect ? memf(mem_address) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_run(input logic [9:0] b, input logic [10:0] n);
    base_addr = b; length = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic capture(input int ncyc, input int hold, input int restart_at);
    q_data.delete(); q_last.delete(); q_addr.delete();
    n_done = 0; done_cyc = 0; busy_cnt = 0; last_busy = 0; first_valid = 0;
    first_cs = 0; cs_hold = 0; n_last = 0; stray_last = 0;
    for (int c = 1; c <= ncyc; c++) begin
      out_ready = (c > hold);
      start = (c == restart_at);
      if (c == restart_at) begin base_addr = 10'h100; length = 11'd3; end
      #0;
      if (mem_chipselect) begin
        q_addr.push_back(mem_address);
        if (first_cs == 0) first_cs = c;
        if (c <= hold) cs_hold++;
      end
      if (out_valid && first_valid == 0) first_valid = c;
      if (out_last && !out_valid) stray_last++;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data); q_last.push_back(out_last);
        if (out_last) n_last++;
      end
      if (busy) begin busy_cnt++; last_busy = c; end
      if (done) begin n_done++; done_cyc = c; end
      tick();
    end
    start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; out_ready = 1'b1; base_addr = '0; length = '0;
    tick(); tick();
    vecs++;
    if ({busy, done, mem_chipselect, mem_clken, out_valid, out_last, mem_address, out_data} !== '0) begin
      errs++; $display("FAIL reset_outputs: got busy=%b done=%b cs=%b clken=%b v=%b l=%b a=%h d=%h want all 0",
        busy, done, mem_chipselect, mem_clken, out_valid, out_last, mem_address, out_data);
    end
    reset = 1'b0; tick();
    vecs++;
    if ({mem_clken, busy, out_valid} !== 3'b100) begin
      errs++; $display("FAIL post_reset: got clken=%b busy=%b valid=%b want 1 0 0", mem_clken, busy, out_valid);
    end
  endtask

  task automatic test_basic();
    start_run(10'h010, 11'd4);
    capture(12, 0, 0);
    vecs++; if (q_addr.size() !== 4) begin errs++; $display("FAIL basic_nreq: got %0d want 4", q_addr.size()); end
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      vecs++; if (q_addr[i] !== 10'(10'h010 + i)) begin errs++; $display("FAIL basic_addr[%0d]: got %h want %h", i, q_addr[i], 10'(10'h010 + i)); end
    end
    vecs++; if (q_data.size() !== 4) begin errs++; $display("FAIL basic_nwords: got %0d want 4", q_data.size()); end
    for (int i = 0; i < 4 && i < q_data.size(); i++) begin
      vecs++; if (q_data[i] !== memf(10'(10'h010 + i)) || q_last[i] !== (i == 3)) begin
        errs++; $display("FAIL basic_word[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], memf(10'(10'h010 + i)), (i == 3));
      end
    end
    vecs++; if (first_cs !== 1) begin errs++; $display("FAIL basic_first_req: got cycle %0d want 1", first_cs); end
    vecs++; if (first_valid !== 3) begin errs++; $display("FAIL basic_first_valid: got cycle %0d want 3", first_valid); end
    vecs++; if (done_cyc !== 7 || n_done !== 1) begin errs++; $display("FAIL basic_done: got cycle %0d count %0d want 7 1", done_cyc, n_done); end
    vecs++; if (busy_cnt !== 6 || last_busy !== 6) begin errs++; $display("FAIL basic_busy: got %0d cycles last %0d want 6 6", busy_cnt, last_busy); end
    vecs++; if (stray_last !== 0) begin errs++; $display("FAIL basic_stray_last: got %0d want 0", stray_last); end
  endtask

  task automatic test_wrap();
    logic [9:0] exp_a [4];
    exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
    start_run(10'h3FE, 11'd4);
    capture(12, 0, 0);
    vecs++; if (q_addr.size() !== 4 || q_data.size() !== 4) begin
      errs++; $display("FAIL wrap_counts: got %0d req %0d words want 4 4", q_addr.size(), q_data.size());
    end
    for (int i = 0; i < 4 && i < q_addr.size() && i < q_data.size(); i++) begin
      vecs++; if (q_addr[i] !== exp_a[i] || q_data[i] !== memf(exp_a[i])) begin
        errs++; $display("FAIL wrap[%0d]: got a=%h d=%h want a=%h d=%h", i, q_addr[i], q_data[i], exp_a[i], memf(exp_a[i]));
      end
    end
    vecs++; if (n_done !== 1) begin errs++; $display("FAIL wrap_done: got %0d want 1", n_done); end
  endtask

  task automatic test_backpressure();
    start_run(10'h200, 11'd16);
    capture(60, 20, 0);
    vecs++; if (cs_hold !== 4) begin errs++; $display("FAIL bp_credits: got %0d requests while stalled want 4", cs_hold); end
    vecs++; if (q_data.size() !== 16) begin errs++; $display("FAIL bp_nwords: got %0d want 16", q_data.size()); end
    for (int i = 0; i < 16 && i < q_data.size(); i++) begin
      vecs++; if (q_data[i] !== memf(10'(10'h200 + i)) || q_last[i] !== (i == 15)) begin
        errs++; $display("FAIL bp_word[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], memf(10'(10'h200 + i)), (i == 15));
      end
    end
    vecs++; if (n_last !== 1 || n_done !== 1 || stray_last !== 0) begin
      errs++; $display("FAIL bp_last_done: got last=%0d done=%0d stray=%0d want 1 1 0", n_last, n_done, stray_last);
    end
  endtask

  task automatic test_zero_length();
    start_run(10'h055, 11'd0);
    capture(5, 0, 0);
    vecs++; if (done_cyc !== 1 || n_done !== 1) begin errs++; $display("FAIL zero_done: got cycle %0d count %0d want 1 1", done_cyc, n_done); end
    vecs++; if (busy_cnt !== 0 || q_addr.size() !== 0 || q_data.size() !== 0) begin
      errs++; $display("FAIL zero_activity: got busy=%0d req=%0d words=%0d want 0 0 0", busy_cnt, q_addr.size(), q_data.size());
    end
  endtask

  task automatic test_restart_ignored();
    start_run(10'h040, 11'd8);
    capture(20, 0, 2);
    vecs++; if (q_addr.size() !== 8 || q_data.size() !== 8) begin
      errs++; $display("FAIL restart_counts: got %0d req %0d words want 8 8", q_addr.size(), q_data.size());
    end
    for (int i = 0; i < 8 && i < q_addr.size() && i < q_data.size(); i++) begin
      vecs++; if (q_addr[i] !== 10'(10'h040 + i) || q_data[i] !== memf(10'(10'h040 + i))) begin
        errs++; $display("FAIL restart_word[%0d]: got a=%h d=%h want a=%h d=%h", i, q_addr[i], q_data[i], 10'(10'h040 + i), memf(10'(10'h040 + i)));
      end
    end
    vecs++; if (n_done !== 1 || n_last !== 1 || done_cyc !== 11) begin
      errs++; $display("FAIL restart_done: got done=%0d@%0d last=%0d want 1@11 1", n_done, done_cyc, n_last);
    end
  endtask

  task automatic test_reset_mid_run();
    int stale;
    start_run(10'h050, 11'd8);
    tick(); tick();
    reset = 1'b1; #1;
    vecs++; if ({busy, done, mem_chipselect, mem_clken, out_valid, out_last, mem_address, out_data} !== '0) begin
      errs++; $display("FAIL midreset_outputs: got busy=%b cs=%b clken=%b v=%b a=%h d=%h want all 0",
        busy, mem_chipselect, mem_clken, out_valid, mem_address, out_data);
    end
    tick(); reset = 1'b0;
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid || busy || done || mem_chipselect) stale++;
    end
    vecs++; if (stale !== 0) begin errs++; $display("FAIL midreset_stale: got %0d active cycles want 0", stale); end
    start_run(10'h020, 11'd2);
    capture(12, 0, 0);
    vecs++; if (q_data.size() !== 2 || q_addr.size() !== 2) begin
      errs++; $display("FAIL midreset_counts: got %0d words %0d req want 2 2", q_data.size(), q_addr.size());
    end
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      vecs++; if (q_data[i] !== memf(10'(10'h020 + i)) || q_last[i] !== (i == 1)) begin
        errs++; $display("FAIL midreset_word[%0d]: got %h/%b want %h/%b", i, q_data[i], q_last[i], memf(10'(10'h020 + i)), (i == 1));
      end
    end
    vecs++; if (n_done !== 1) begin errs++; $display("FAIL midreset_done: got %0d want 1", n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_restart_ignored();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
